// File: rtl/dff_chk_pkg.sv
// Shared types and constants for the DFF response checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } chk_state_e;

    localparam int CNT_W_DEFAULT = 16;
    // All-ones counter value for the default width; counters stick here.
    localparam logic [CNT_W_DEFAULT-1:0] CNT_SAT = {CNT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/dff_response_checker_if.sv
// Stimulus/response and result signals between the DFF bench and the response checker.
interface dff_response_checker_if #(parameter int CNT_W = 16);

    logic             start;
    logic             stop;
    logic             d;
    logic             q;
    logic             qn;
    logic             busy;
    logic             done;
    logic             pass;
    logic             qn_err;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_cyc;

    modport master (
        output start, stop, d, q, qn,
        input  busy, done, pass, qn_err, chk_cnt, err_cnt, first_err_cyc
    );

    modport slave (
        input  start, stop, d, q, qn,
        output busy, done, pass, qn_err, chk_cnt, err_cnt, first_err_cyc
    );

endinterface

// File: rtl/dff_chk_exp_pipe.sv
// LATENCY-deep delay line on d; exp is d as sampled LATENCY edges ago.
module dff_chk_exp_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic exp
);

    logic [LATENCY-1:0] pipe_r;

    if (LATENCY == 1) begin : g_single
        // Single-stage delay
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_r <= 1'b0;
            end else begin
                pipe_r <= d;
            end
        end
    end else begin : g_multi
        // Multi-stage shift toward the MSB
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_r <= '0;
            end else begin
                pipe_r <= {pipe_r[LATENCY-2:0], d};
            end
        end
    end

    assign exp = pipe_r[LATENCY-1];

endmodule

// File: rtl/dff_response_checker.sv
// Checks a flip-flop's q (and optionally qn) against a delayed copy of its d input.
// Optional feature macro: DFF_CHK_QN_CHECK_EN enables the qn==~q check feeding pass.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int LATENCY  = 1,
    parameter int CNT_W    = 16,
    parameter int N_CHECKS = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    dff_response_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int               WCNT_W  = $clog2(LATENCY + 1);

    chk_state_e       state_r, state_nxt;
    logic [WCNT_W-1:0] wcnt_r, wcnt_nxt;
    logic [CNT_W-1:0] chk_cnt_r, chk_cnt_nxt;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt;
    logic [CNT_W-1:0] first_r, first_nxt;
    logic             qn_err_r, qn_err_nxt;
    logic             pass_r, pass_nxt;
    logic             busy_r, done_r;
    logic             exp_s;
    logic             mismatch_s;
    logic             final_s;
    logic [CNT_W:0]   chk_inc_s;

    dff_chk_exp_pipe #(.LATENCY(LATENCY)) u_exp_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.d),
        .exp   (exp_s)
    );

    // Case inequality so an unknown q is reported as a mismatch in simulation.
    assign mismatch_s = (bus.q !== exp_s);
    assign chk_inc_s  = {1'b0, chk_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign final_s    = (N_CHECKS != 0) && (chk_inc_s == (CNT_W+1)'(N_CHECKS));

`ifndef DFF_CHK_QN_CHECK_EN
    logic unused_qn_s;
    assign unused_qn_s = bus.qn;
`endif

    // Next-state, counter and result logic
    always_comb begin
        state_nxt   = state_r;
        wcnt_nxt    = wcnt_r;
        chk_cnt_nxt = chk_cnt_r;
        err_cnt_nxt = err_cnt_r;
        first_nxt   = first_r;
        qn_err_nxt  = qn_err_r;
        pass_nxt    = pass_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = WARMUP;
                    wcnt_nxt    = '0;
                    chk_cnt_nxt = '0;
                    err_cnt_nxt = '0;
                    first_nxt   = CNT_MAX;
                    qn_err_nxt  = 1'b0;
                    pass_nxt    = 1'b0;
                end else begin
                    state_nxt = state_r;
                end
            end
            WARMUP: begin
                if (bus.stop) begin
                    state_nxt = DONE;
                end else if (wcnt_r == WCNT_W'(LATENCY - 1)) begin
                    state_nxt = CHECK;
                end else begin
                    wcnt_nxt = wcnt_r + WCNT_W'(1);
                end
            end
            CHECK: begin
                if (chk_cnt_r != CNT_MAX) begin
                    chk_cnt_nxt = chk_inc_s[CNT_W-1:0];
                end else begin
                    chk_cnt_nxt = chk_cnt_r;
                end
                if (mismatch_s) begin
                    if (err_cnt_r != CNT_MAX) begin
                        err_cnt_nxt = err_cnt_r + CNT_W'(1);
                    end else begin
                        err_cnt_nxt = err_cnt_r;
                    end
                    // A zero error count means this is the first mismatch of the run.
                    if (err_cnt_r == '0) begin
                        first_nxt = chk_cnt_r;
                    end else begin
                        first_nxt = first_r;
                    end
                end else begin
                    err_cnt_nxt = err_cnt_r;
                end
`ifdef DFF_CHK_QN_CHECK_EN
                if (bus.qn == bus.q) begin
                    qn_err_nxt = 1'b1;
                end else begin
                    qn_err_nxt = qn_err_r;
                end
`endif
                if (bus.stop || final_s) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CHECK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if ((state_nxt == DONE) && (state_r != DONE)) begin
            pass_nxt = (err_cnt_nxt == '0) && !qn_err_nxt && (chk_cnt_nxt != '0);
        end else begin
            pass_nxt = pass_nxt;
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            wcnt_r    <= '0;
            chk_cnt_r <= '0;
            err_cnt_r <= '0;
            first_r   <= CNT_MAX;
            qn_err_r  <= 1'b0;
            pass_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            wcnt_r    <= wcnt_nxt;
            chk_cnt_r <= chk_cnt_nxt;
            err_cnt_r <= err_cnt_nxt;
            first_r   <= first_nxt;
            qn_err_r  <= qn_err_nxt;
            pass_r    <= pass_nxt;
            busy_r    <= (state_nxt == WARMUP) || (state_nxt == CHECK);
            done_r    <= (state_nxt == DONE);
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.pass          = pass_r;
    assign bus.qn_err        = qn_err_r;
    assign bus.chk_cnt       = chk_cnt_r;
    assign bus.err_cnt       = err_cnt_r;
    assign bus.first_err_cyc = first_r;

endmodule

// File: tb/tb_dff_response_checker.sv
// Self-checking bench: table-driven runs, random runs against a reference model, corner sequences.
module tb_dff_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic dv [0:63];
    logic qv [0:63];

    always #5 clk = ~clk;

    dff_response_checker_if #(.CNT_W(16)) b0 ();
    dff_response_checker_if #(.CNT_W(16)) b3 ();
    dff_response_checker_if #(.CNT_W(4))  b4 ();

    dff_response_checker #(.LATENCY(1), .CNT_W(16), .N_CHECKS(20)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    dff_response_checker #(.LATENCY(3), .CNT_W(16), .N_CHECKS(0))  u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    dff_response_checker #(.LATENCY(1), .CNT_W(4),  .N_CHECKS(0))  u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        int   flip_a;
        int   flip_b;
        int   qn_g;
        int   exp_err;
        int   exp_first;
        logic exp_pass;
        logic exp_qn_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One run on u0: start, then drive an ideal DFF response with optional faults until done.
    task automatic run0(input int flip_a, input int flip_b, input int qn_g, input bit rnd,
                        output int edges);
        logic [15:0] pat;
        logic        nq;
        int          j;
        pat = 16'b1011_0110_1101_0010;
        edges = -1;
        @(negedge clk);
        b0.start = 1'b1;
        dv[0] = b0.d;
        qv[0] = b0.q;
        @(posedge clk);
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
            if (c == 1) chk("busy_after_start", {31'd0, b0.busy}, 32'd1);
            if (b0.done) begin
                edges = c - 1;
                break;
            end
            j = c - 2;
            if (rnd) nq = b0.d ^ ($urandom_range(0, 5) == 0);
            else     nq = b0.d ^ ((j == flip_a) || (j == flip_b));
            b0.q  = nq;
            b0.qn = (j == qn_g) ? nq : ~nq;
            b0.d  = rnd ? 1'($urandom_range(0, 1)) : pat[c % 16];
            dv[c] = b0.d;
            qv[c] = b0.q;
            @(posedge clk);
        end
    endtask

    vec_t vecs [5];
    int   edges;
    int   m_err;
    int   m_first;

    initial begin
        b0.start = 1'b0; b0.stop = 1'b0; b0.d = 1'b0; b0.q = 1'b0; b0.qn = 1'b1;
        b3.start = 1'b0; b3.stop = 1'b0; b3.d = 1'b0; b3.q = 1'b0; b3.qn = 1'b1;
        b4.start = 1'b0; b4.stop = 1'b0; b4.d = 1'b1; b4.q = 1'b0; b4.qn = 1'b1;

        vecs[0] = '{-100, -100, -100, 0, 32'hFFFF, 1'b1, 1'b0};
        vecs[1] = '{5,    9,    -100, 2, 5,        1'b0, 1'b0};
        vecs[2] = '{0,    -100, -100, 1, 0,        1'b0, 1'b0};
        vecs[3] = '{19,   -100, -100, 1, 19,       1'b0, 1'b0};
`ifdef DFF_CHK_QN_CHECK_EN
        vecs[4] = '{-100, -100, 3,    0, 32'hFFFF, 1'b0, 1'b1};
`else
        vecs[4] = '{-100, -100, 3,    0, 32'hFFFF, 1'b1, 1'b0};
`endif

        // Reset values, then reset in the middle of a check run
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_first_err", {16'd0, b0.first_err_cyc}, 32'hFFFF);
        rst_n = 1'b1;
        @(negedge clk);
        b0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b0.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_run", {31'd0, b0.busy}, 32'd1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("rst_done", {31'd0, b0.done}, 32'd0);
        chk("rst_chk_cnt", {16'd0, b0.chk_cnt}, 32'd0);
        chk("rst_err_cnt", {16'd0, b0.err_cnt}, 32'd0);
        chk("rst_first_err_mid", {16'd0, b0.first_err_cyc}, 32'hFFFF);
        chk("rst_pass", {31'd0, b0.pass}, 32'd0);
        rst_n = 1'b1;

        // Table-driven runs on the 20-check instance
        for (int i = 0; i < 5; i++) begin
            run0(vecs[i].flip_a, vecs[i].flip_b, vecs[i].qn_g, 1'b0, edges);
            chk($sformatf("v%0d_edges", i), edges, 32'd21);
            chk($sformatf("v%0d_chk_cnt", i), {16'd0, b0.chk_cnt}, 32'd20);
            chk($sformatf("v%0d_err_cnt", i), {16'd0, b0.err_cnt}, vecs[i].exp_err);
            chk($sformatf("v%0d_first_err", i), {16'd0, b0.first_err_cyc}, vecs[i].exp_first);
            chk($sformatf("v%0d_pass", i), {31'd0, b0.pass}, {31'd0, vecs[i].exp_pass});
            chk($sformatf("v%0d_qn_err", i), {31'd0, b0.qn_err}, {31'd0, vecs[i].exp_qn_err});
        end

        // Random q faults, judged by comparing q at each check edge with d one edge earlier
        for (int r = 0; r < 8; r++) begin
            run0(-100, -100, -100, 1'b1, edges);
            m_err = 0;
            m_first = 32'hFFFF;
            for (int j = 0; j < 20; j++) begin
                if (qv[j + 2] != dv[j + 1]) begin
                    if (m_err == 0) m_first = j;
                    m_err++;
                end
            end
            chk($sformatf("r%0d_edges", r), edges, 32'd21);
            chk($sformatf("r%0d_chk_cnt", r), {16'd0, b0.chk_cnt}, 32'd20);
            chk($sformatf("r%0d_err_cnt", r), {16'd0, b0.err_cnt}, m_err);
            chk($sformatf("r%0d_first_err", r), {16'd0, b0.first_err_cyc}, m_first);
            chk($sformatf("r%0d_pass", r), {31'd0, b0.pass}, {31'd0, m_err == 0});
        end

        // LATENCY=3: stop on the 2nd warmup edge, then a start pulse during CHECK is ignored
        @(negedge clk); b3.start = 1'b1;
        @(posedge clk);
        @(negedge clk); b3.start = 1'b0;
        @(posedge clk);
        @(negedge clk); b3.stop = 1'b1;
        @(posedge clk);
        @(negedge clk); b3.stop = 1'b0;
        chk("warm_stop_done", {31'd0, b3.done}, 32'd1);
        chk("warm_stop_busy", {31'd0, b3.busy}, 32'd0);
        chk("warm_stop_chk_cnt", {16'd0, b3.chk_cnt}, 32'd0);
        chk("warm_stop_pass", {31'd0, b3.pass}, 32'd0);
        b3.start = 1'b1;
        @(posedge clk);
        @(negedge clk); b3.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); b3.start = 1'b1;
        @(posedge clk);
        @(negedge clk); b3.start = 1'b0;
        chk("ign_start_busy", {31'd0, b3.busy}, 32'd1);
        chk("ign_start_chk_cnt", {16'd0, b3.chk_cnt}, 32'd3);
        repeat (2) @(posedge clk);
        @(negedge clk); b3.stop = 1'b1;
        @(posedge clk);
        @(negedge clk); b3.stop = 1'b0;
        chk("l3_done", {31'd0, b3.done}, 32'd1);
        chk("l3_chk_cnt", {16'd0, b3.chk_cnt}, 32'd6);
        chk("l3_err_cnt", {16'd0, b3.err_cnt}, 32'd0);
        chk("l3_pass", {31'd0, b3.pass}, 32'd1);

        // CNT_W=4 saturation: q stuck at 0 while d=1 for 20 check edges
        @(negedge clk); b4.start = 1'b1;
        @(posedge clk);
        @(negedge clk); b4.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); b4.stop = 1'b1;
        @(posedge clk);
        @(negedge clk); b4.stop = 1'b0;
        chk("sat_done", {31'd0, b4.done}, 32'd1);
        chk("sat_chk_cnt", {28'd0, b4.chk_cnt}, 32'd15);
        chk("sat_err_cnt", {28'd0, b4.err_cnt}, 32'd15);
        chk("sat_first_err", {28'd0, b4.first_err_cyc}, 32'd0);
        chk("sat_pass", {31'd0, b4.pass}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
